// File: rtl/ibus_mem_responder.sv
// ibus_mem_responder: the memory end of the CPU instruction bus. It holds
// read-only storage and returns fetch words in order after LATENCY cycles.
// Optional feature macro: IBUS_RESP_RANDOM_STALL_EN adds LFSR-driven random
// backpressure on top of occupancy-based stall.
//
// Handshake: a request transfers on a rising edge where read=1 and stall=0;
// address is sampled on that edge. A response is present in any cycle with
// valid=1 and is consumed unconditionally (the fetch side cannot refuse it);
// rddata and addr_err are meaningful only while valid=1.
module ibus_mem_responder #(
  parameter int DATA_WIDTH      = 64,
  parameter int MEM_WORDS       = 4096,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic [31:0]           address,
  input  logic                  flush,
  output logic                  stall,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rddata,
  output logic                  addr_err
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  // Storage is loaded externally (bench or synthesis-time init), never by the CPU.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Response pipeline: valid bit, word index and error bit per stage.
  logic [LATENCY-1:0] st_v;
  logic [LATENCY-1:0] st_e;
  logic [IDX_W-1:0]   st_idx [LATENCY];

  logic [CNT_W-1:0] outstanding;
  logic             accept;
  logic             emit;
  logic             rand_stall;
  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic             addr_unused;

  // Entry feeding the last stage; the data read happens on that transfer so
  // rddata becomes valid together with the last-stage valid bit.
  logic             last_in_v;
  logic             last_in_e;
  logic [IDX_W-1:0] last_in_idx;

  assign req_idx     = address[OFF_W +: IDX_W];
  assign req_err     = |address[31:OFF_W+IDX_W];
  assign addr_unused = ^address[OFF_W-1:0];

  assign emit     = st_v[LATENCY-1];
  assign valid    = st_v[LATENCY-1];
  assign addr_err = st_e[LATENCY-1];

  assign stall  = ((outstanding == CNT_MAX) && !emit) || rand_stall;
  assign accept = read && !stall && !rst;

  if (LATENCY == 1) begin : g_lat1
    // Stage 0 is the last stage: a request accepted with flush survives.
    assign last_in_v   = accept;
    assign last_in_e   = req_err;
    assign last_in_idx = req_idx;
  end else begin : g_latn
    assign last_in_v   = st_v[LATENCY-2] && !flush;
    assign last_in_e   = st_e[LATENCY-2];
    assign last_in_idx = st_idx[LATENCY-2];
  end

  // Valid/error shift: stage 0 takes the accepted request, flush kills the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_v <= '0;
      st_e <= '0;
    end else begin
      st_v[0] <= accept;
      st_e[0] <= req_err;
      for (int i = 1; i < LATENCY; i++) begin
        st_v[i] <= st_v[i-1] && !flush;
        st_e[i] <= st_e[i-1];
      end
    end
  end

  // Index shift; meaningless without its valid bit, so no reset needed.
  always_ff @(posedge clk) begin
    st_idx[0] <= req_idx;
    for (int i = 1; i < LATENCY; i++) begin
      st_idx[i] <= st_idx[i-1];
    end
  end

  // Registered read data; out-of-range requests return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rddata <= '0;
    end else if (last_in_v) begin
      rddata <= last_in_e ? '0 : mem[last_in_idx];
    end
  end

  // Occupancy: accepted-but-unanswered requests; flush keeps only a new accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (flush) begin
      outstanding <= CNT_W'(accept);
    end else if (accept && !emit) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!accept && emit) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

`ifdef IBUS_RESP_RANDOM_STALL_EN
  logic [31:0] lfsr;

  // Fibonacci LFSR, taps 32,22,2,1; stalls roughly one cycle in eight.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 32'h1;
    end else begin
      lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end
  end

  assign rand_stall = (lfsr[2:0] == 3'b000);
`else
  assign rand_stall = 1'b0;
`endif

endmodule
